uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning oversample ticks per stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 The block SHALL have port clk_i, input, 1 bit, single system clock with all flops on the rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port rx_i, input, 1 bit, asynchronous serial line that idles high.
REQ-006 The block SHALL have port s_tick_i, input, 1 bit, one-clk-wide 16x-oversample tick from the baud generator.
REQ-007 The block SHALL have port dout_o, output, DBIT bits, last received data word.
REQ-008 The block SHALL have port rx_done_tick_o, output, 1 bit, one-clk pulse on frame completion.
REQ-009 The block SHALL have port frame_err_o, output, 1 bit, stop-bit error flag for the last frame.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer (flops reset to 1) before use; rx_s denotes the synchronized value.
REQ-011 FSM SHALL have states IDLE, START, DATA, STOP, a 4-bit tick counter s, a data-bit counter n (clog2(DBIT) bits) and a DBIT-bit shift register b.
REQ-012 In IDLE, rx_s==0 SHALL move to START with s=0, regardless of s_tick_i.
REQ-013 All counting in START/DATA/STOP SHALL advance only on clk edges where s_tick_i==1; state, s, n and b SHALL hold otherwise.
REQ-014 In START on a tick with s==7 (mid start bit): rx_s==0 SHALL move to DATA with s=0 and n=0; rx_s==1 SHALL return to IDLE as a glitch, with no output change.
REQ-015 In START, DATA and STOP on a tick with s below its terminal value, s SHALL increment by 1.
REQ-016 In DATA on a tick with s==15: s SHALL go to 0 and b SHALL go to {rx_s, b[DBIT-1:1]} (LSB first); n==DBIT-1 SHALL move to STOP, otherwise n SHALL increment.
REQ-017 In STOP on a tick with s==SB_TICK-1, the block SHALL move to IDLE and SHALL load dout_o<=b and frame_err_o<=~rx_s at that same edge.
REQ-018 rx_done_tick_o SHALL be a registered pulse, high for exactly the one clk cycle following the edge of REQ-017, coincident with the new dout_o and frame_err_o.
REQ-019 dout_o and frame_err_o SHALL hold their values until the next completed frame; frame_err_o SHALL NOT be sticky.
REQ-020 A frame whose stop bit is low SHALL still pulse rx_done_tick_o and update dout_o.
REQ-021 After STOP→IDLE, a start bit that is already low (back-to-back frame) SHALL be detected on the next clk edge per REQ-012.
REQ-022 Latency SHALL be start-bit falling edge to rx_done_tick_o = 2 synchronizer clks + (8 + 16·DBIT + SB_TICK) ticks + 1 clk, ±1 tick of alignment.
REQ-023 The s counter SHALL never exceed SB_TICK-1 (SB_TICK ≤ 16 fits 4 bits; for SB_TICK = 32, s SHALL widen to 5 bits).

Reset
REQ-024 reset_i==0 SHALL immediately force state=IDLE, s=0, n=0, b=0, dout_o=0, rx_done_tick_o=0, frame_err_o=0, and synchronizer flops=1, at any point including mid-frame.
REQ-025 After reset_i deasserts, the block SHALL wait for a fresh falling edge; a partial frame SHALL never produce rx_done_tick_o.

Verification
REQ-026 Reset scenario: assert reset_i=0 with rx_i=1 -> dout_o=0x00, rx_done_tick_o=0, frame_err_o=0.
REQ-027 Good frame scenario: bench tick every 4 clks, send 0xA5 LSB first, 16 ticks/bit, stop=1 -> exactly one rx_done_tick_o pulse of 1 clk, dout_o=0xA5, frame_err_o=0.
REQ-028 Glitch scenario: rx_i low for 4 ticks then high -> no pulse, FSM back in IDLE; then send 0x3C -> dout_o=0x3C.
REQ-029 Framing error scenario: send 0x55 with stop bit 0 -> pulse, dout_o=0x55, frame_err_o=1; then a good 0x0F frame -> frame_err_o=0.
REQ-030 Mid-frame reset scenario: reset_i=0 during data bit 3 of 0x81 -> outputs 0, no pulse; then send 0xFF -> dout_o=0xFF, one pulse.
REQ-031 Back-to-back scenario: send 0x00 then 0xFF with zero idle gap -> two pulses, dout_o=0x00 then 0xFF, frame_err_o=0 both times.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver with framing-error flag
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            rx_i,
    input  logic            s_tick_i,
    output logic [DBIT-1:0] dout_o,
    output logic            rx_done_tick_o,
    output logic            frame_err_o
);

    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam int NW = $clog2(DBIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_r, state_n;
    logic [SW-1:0]   s_r, s_n;
    logic [NW-1:0]   n_r, n_n;
    logic [DBIT-1:0] b_r, b_n;
    logic [DBIT-1:0] dout_n;
    logic            ferr_n, done_n;
    logic            rx_meta, rx_s;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r        <= IDLE;
            s_r            <= '0;
            n_r            <= '0;
            b_r            <= '0;
            dout_o         <= '0;
            frame_err_o    <= 1'b0;
            rx_done_tick_o <= 1'b0;
        end else begin
            state_r        <= state_n;
            s_r            <= s_n;
            n_r            <= n_n;
            b_r            <= b_n;
            dout_o         <= dout_n;
            frame_err_o    <= ferr_n;
            rx_done_tick_o <= done_n;
        end
    end

    always_comb begin
        state_n = state_r;
        s_n     = s_r;
        n_n     = n_r;
        b_n     = b_r;
        dout_n  = dout_o;
        ferr_n  = frame_err_o;
        done_n  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit; a high level here is a glitch.
                if (s_tick_i) begin
                    if (s_r == SW'(7)) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s_r + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick_i) begin
                    if (s_r == SW'(15)) begin
                        s_n = '0;
                        b_n = {rx_s, b_r[DBIT-1:1]};
                        if (n_r == NW'(DBIT - 1)) begin
                            state_n = STOP;
                        end else begin
                            n_n = n_r + NW'(1);
                        end
                    end else begin
                        s_n = s_r + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick_i) begin
                    if (s_r == SW'(SB_TICK - 1)) begin
                        state_n = IDLE;
                        dout_n  = b_r;
                        ferr_n  = ~rx_s;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s_r + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
